// File: rtl/multicycle_mips_core.sv
// rtl/multicycle_mips_core.sv - multicycle MIPS subset core with MMIO port and handshake bus
// FETCH/DECODE/EXEC/MEM/WB sequencer; unsupported or misaligned operations park in TRAP.
module multicycle_mips_core #(
  parameter logic [31:0] RESET_PC      = 32'h0040_0000,
  parameter int          PORT_IN_W     = 8,
  parameter logic [31:0] PORT_IN_ADDR  = 32'hFFFF_0000,
  parameter logic [31:0] PORT_OUT_ADDR = 32'hFFFF_0004
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [PORT_IN_W-1:0] PortIn,
  output logic [31:0]          PortOut,
  output logic [31:0]          ALUResultOut,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [31:0]          mem_addr,
  output logic [31:0]          mem_wdata,
  input  logic [31:0]          mem_rdata,
  input  logic                 mem_ready,
  output logic                 retire,
  output logic                 halted
);
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_t;

  state_t      r_state;
  logic [31:0] r_pc, r_ir, r_a, r_b, r_alu, r_mdr, r_port_out;
  logic [31:0] r_regs [32];

  logic [5:0]  w_op, w_funct;
  logic [4:0]  w_rs, w_rt, w_rd, w_shamt, w_wb_dst;
  logic [31:0] w_imm_s, w_imm_z, w_port_in, w_res, w_br_target;
  logic        w_alu, w_branch, w_taken, w_jump, w_jr, w_ldst, w_bad;
  logic        w_lw, w_sw, w_mmio;

  assign w_op        = r_ir[31:26];
  assign w_rs        = r_ir[25:21];
  assign w_rt        = r_ir[20:16];
  assign w_rd        = r_ir[15:11];
  assign w_shamt     = r_ir[10:6];
  assign w_funct     = r_ir[5:0];
  assign w_imm_s     = {{16{r_ir[15]}}, r_ir[15:0]};
  assign w_imm_z     = {16'h0000, r_ir[15:0]};
  assign w_lw        = (w_op == 6'h23);
  assign w_sw        = (w_op == 6'h2B);
  assign w_mmio      = (r_alu == PORT_IN_ADDR) || (r_alu == PORT_OUT_ADDR);
  assign w_wb_dst    = (w_op == 6'h00) ? w_rd : w_rt;
  assign w_br_target = r_pc + (w_imm_s << 2);

  always_comb begin
    w_port_in = '0;
    w_port_in[PORT_IN_W-1:0] = PortIn;
  end

  // Decode and execute in one place; w_bad covers both illegal encodings and misalignment.
  always_comb begin
    w_res    = 32'h0;
    w_alu    = 1'b0;
    w_branch = 1'b0;
    w_taken  = 1'b0;
    w_jump   = 1'b0;
    w_jr     = 1'b0;
    w_ldst   = 1'b0;
    w_bad    = 1'b0;
    case (w_op)
      6'h00: begin
        w_alu = 1'b1;
        case (w_funct)
          6'h20: w_res = r_a + r_b;
          6'h22: w_res = r_a - r_b;
          6'h24: w_res = r_a & r_b;
          6'h25: w_res = r_a | r_b;
          6'h27: w_res = ~(r_a | r_b);
          6'h2A: w_res = {31'h0, $signed(r_a) < $signed(r_b)};
          6'h00: w_res = r_b << w_shamt;
          6'h02: w_res = r_b >> w_shamt;
          6'h08: begin
            w_alu = 1'b0;
            w_jr  = 1'b1;
            w_res = r_a;
            w_bad = |r_a[1:0];
          end
          default: begin
            w_alu = 1'b0;
            w_bad = 1'b1;
          end
        endcase
      end
      6'h08: begin w_alu = 1'b1; w_res = r_a + w_imm_s; end
      6'h0A: begin w_alu = 1'b1; w_res = {31'h0, $signed(r_a) < $signed(w_imm_s)}; end
      6'h0C: begin w_alu = 1'b1; w_res = r_a & w_imm_z; end
      6'h0D: begin w_alu = 1'b1; w_res = r_a | w_imm_z; end
      6'h0F: begin w_alu = 1'b1; w_res = {r_ir[15:0], 16'h0000}; end
      6'h04: begin w_branch = 1'b1; w_res = r_a - r_b; w_taken = (r_a == r_b); end
      6'h05: begin w_branch = 1'b1; w_res = r_a - r_b; w_taken = (r_a != r_b); end
      6'h02, 6'h03: begin w_jump = 1'b1; w_res = r_pc; end
      6'h23, 6'h2B: begin
        w_ldst = 1'b1;
        w_res  = r_a + w_imm_s;
        w_bad  = |w_res[1:0];
      end
      default: w_bad = 1'b1;
    endcase
  end

  assign mem_req      = reset && ((r_state == S_FETCH) || (r_state == S_MEM && !w_mmio));
  assign mem_we       = reset && (r_state == S_MEM) && !w_mmio && w_sw;
  assign mem_addr     = (r_state == S_MEM) ? r_alu : r_pc;
  assign mem_wdata    = r_b;
  assign retire       = reset && ((r_state == S_WB) ||
                        (r_state == S_EXEC && !w_bad && (w_branch || w_jump || w_jr)) ||
                        (r_state == S_MEM && w_sw && (w_mmio || mem_ready)));
  assign halted       = (r_state == S_TRAP);
  assign PortOut      = r_port_out;
  assign ALUResultOut = r_alu;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_FETCH;
      r_pc       <= RESET_PC;
      r_ir       <= 32'h0;
      r_a        <= 32'h0;
      r_b        <= 32'h0;
      r_alu      <= 32'h0;
      r_mdr      <= 32'h0;
      r_port_out <= 32'h0;
      for (int i = 0; i < 32; i++) r_regs[i] <= 32'h0;
    end else begin
      case (r_state)
        S_FETCH: if (mem_ready) begin
          r_ir    <= mem_rdata;
          r_pc    <= r_pc + 32'd4;
          r_state <= S_DECODE;
        end
        S_DECODE: begin
          r_a     <= r_regs[w_rs];
          r_b     <= r_regs[w_rt];
          r_state <= S_EXEC;
        end
        S_EXEC: if (w_bad) begin
          r_state <= S_TRAP;
        end else begin
          r_alu <= w_res;
          if (w_ldst) r_state <= S_MEM;
          else if (w_alu) r_state <= S_WB;
          else begin
            r_state <= S_FETCH;
            if (w_branch && w_taken) r_pc <= w_br_target;
            if (w_jump) r_pc <= {r_pc[31:28], r_ir[25:0], 2'b00};
            if (w_jr) r_pc <= r_a;
            if (w_op == 6'h03) r_regs[31] <= r_pc;
          end
        end
        S_MEM: if (w_mmio) begin
          if (w_sw && r_alu == PORT_OUT_ADDR) r_port_out <= r_b;
          r_mdr   <= (r_alu == PORT_IN_ADDR) ? w_port_in : r_port_out;
          r_state <= w_lw ? S_WB : S_FETCH;
        end else if (mem_ready) begin
          r_mdr   <= mem_rdata;
          r_state <= w_lw ? S_WB : S_FETCH;
        end
        S_WB: begin
          if (w_wb_dst != 5'd0) r_regs[w_wb_dst] <= w_lw ? r_mdr : r_alu;
          r_state <= S_FETCH;
        end
        default: r_state <= S_TRAP;
      endcase
    end
  end
endmodule

// File: tb/tb_multicycle_mips_core.sv
// tb/tb_multicycle_mips_core.sv - directed self-checking bench for multicycle_mips_core
module tb_multicycle_mips_core;
  localparam logic [31:0] RESET_PC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  PortIn = 8'h00;
  logic [31:0] PortOut, ALUResultOut, mem_addr, mem_wdata, mem_rdata;
  logic        mem_req, mem_we, mem_ready, retire, halted;

  logic [31:0] imem [64];
  int          data_wait = 0;
  int          wcnt = 0;
  int          wr_count = 0;
  logic [31:0] wr_addr = 32'h0;
  logic [31:0] wr_data = 32'h0;
  int          checks = 0;
  int          errors = 0;
  logic        is_data;

  multicycle_mips_core dut (
    .clk(clk), .reset(reset), .PortIn(PortIn), .PortOut(PortOut),
    .ALUResultOut(ALUResultOut), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .retire(retire), .halted(halted)
  );

  always #5 clk = ~clk;

  // Data region 0x1001_xxxx returns a pattern derived from the address; writes are captured.
  assign is_data   = (mem_addr[31:16] == 16'h1001);
  assign mem_ready = is_data ? (wcnt == data_wait) : 1'b1;
  always_comb begin
    mem_rdata = 32'h0;
    if (mem_addr[31:16] == 16'h0040) mem_rdata = imem[mem_addr[7:2]];
    else if (is_data) mem_rdata = {16'hBEEF, mem_addr[15:0]};
  end

  always @(posedge clk) begin
    if (mem_req && is_data && !mem_ready) wcnt <= wcnt + 1;
    else wcnt <= 0;
    if (!reset) wr_count <= 0;
    else if (mem_req && mem_we && mem_ready && is_data) begin
      wr_count <= wr_count + 1;
      wr_addr  <= mem_addr;
      wr_data  <= mem_wdata;
    end
  end

  function automatic logic [31:0] f_i(input logic [5:0] op, input logic [4:0] rs,
                                      input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] f_r(input logic [4:0] rs, input logic [4:0] rt,
                                      input logic [4:0] rd, input logic [4:0] sh,
                                      input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  task automatic load_begin();
    @(negedge clk);
    reset = 1'b0;
    data_wait = 0;
    for (int i = 0; i < 64; i++) imem[i] = 32'h0;
    @(negedge clk);
  endtask

  task automatic wait_retire(output int n);
    n = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (retire) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int n;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req: got %b expected 0", mem_req); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we: got %b expected 0", mem_we); end
    checks++; if (retire !== 1'b0) begin errors++; $display("FAIL rst_retire: got %b expected 0", retire); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rst_halted: got %b expected 0", halted); end
    checks++; if (PortOut !== 32'h0) begin errors++; $display("FAIL rst_portout: got %h expected 0", PortOut); end
    checks++; if (ALUResultOut !== 32'h0) begin errors++; $display("FAIL rst_alu: got %h expected 0", ALUResultOut); end
    for (int i = 0; i < 64; i++) imem[i] = 32'h0;
    reset = 1'b1;
    #1;
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rst_fetch_req: got %b expected 1", mem_req); end
    checks++; if (mem_addr !== RESET_PC) begin errors++; $display("FAIL rst_fetch_addr: got %h expected %h", mem_addr, RESET_PC); end
    wait_retire(n);
    checks++; if (n !== 3) begin errors++; $display("FAIL rst_nop_latency: got %0d expected 3", n); end
  endtask

  task automatic test_alu();
    int n;
    load_begin();
    imem[0] = f_i(6'h08, 5'd0, 5'd8, 16'd5);
    imem[1] = f_i(6'h08, 5'd8, 5'd9, 16'hFFF9);
    imem[2] = f_i(6'h0F, 5'd0, 5'd20, 16'hFFFF);
    imem[3] = f_i(6'h2B, 5'd20, 5'd9, 16'd4);
    imem[4] = f_i(6'h08, 5'd0, 5'd0, 16'd9);
    imem[5] = f_i(6'h2B, 5'd20, 5'd0, 16'd4);
    imem[6] = f_r(5'd9, 5'd8, 5'd10, 5'd0, 6'h2A);
    imem[7] = f_i(6'h2B, 5'd20, 5'd10, 16'd4);
    reset = 1'b1;
    wait_retire(n);
    checks++; if (n !== 3) begin errors++; $display("FAIL alu_addi1_cyc: got %0d expected 3", n); end
    checks++; if (ALUResultOut !== 32'd5) begin errors++; $display("FAIL alu_addi1_res: got %h expected 5", ALUResultOut); end
    wait_retire(n);
    checks++; if (n !== 4) begin errors++; $display("FAIL alu_addi2_cyc: got %0d expected 4", n); end
    checks++; if (ALUResultOut !== 32'hFFFF_FFFE) begin errors++; $display("FAIL alu_addi2_res: got %h expected fffffffe", ALUResultOut); end
    wait_retire(n);
    checks++; if (n !== 4) begin errors++; $display("FAIL alu_lui_cyc: got %0d expected 4", n); end
    checks++; if (ALUResultOut !== 32'hFFFF_0000) begin errors++; $display("FAIL alu_lui_res: got %h expected ffff0000", ALUResultOut); end
    wait_retire(n);
    checks++; if (n !== 4) begin errors++; $display("FAIL alu_sw_cyc: got %0d expected 4", n); end
    checks++; if (ALUResultOut !== 32'hFFFF_0004) begin errors++; $display("FAIL alu_sw_addr: got %h expected ffff0004", ALUResultOut); end
    wait_retire(n);
    checks++; if (PortOut !== 32'hFFFF_FFFE) begin errors++; $display("FAIL alu_r9_out: got %h expected fffffffe", PortOut); end
    wait_retire(n);
    wait_retire(n);
    checks++; if (PortOut !== 32'h0) begin errors++; $display("FAIL alu_r0_out: got %h expected 0", PortOut); end
    wait_retire(n);
    @(negedge clk);
    checks++; if (PortOut !== 32'h1) begin errors++; $display("FAIL alu_slt_out: got %h expected 1", PortOut); end
  endtask

  task automatic test_mmio();
    int n;
    load_begin();
    PortIn = 8'h3C;
    imem[0] = f_i(6'h08, 5'd0, 5'd10, 16'h00A5);
    imem[1] = f_i(6'h0F, 5'd0, 5'd20, 16'hFFFF);
    imem[2] = f_i(6'h2B, 5'd20, 5'd10, 16'd4);
    imem[3] = f_i(6'h23, 5'd20, 5'd11, 16'd0);
    imem[4] = f_i(6'h2B, 5'd20, 5'd11, 16'd4);
    reset = 1'b1;
    wait_retire(n);
    wait_retire(n);
    wait_retire(n);
    checks++; if (n !== 4) begin errors++; $display("FAIL mmio_sw_cyc: got %0d expected 4", n); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL mmio_sw_req: got %b expected 0", mem_req); end
    wait_retire(n);
    checks++; if (n !== 5) begin errors++; $display("FAIL mmio_lw_cyc: got %0d expected 5", n); end
    checks++; if (PortOut !== 32'h0000_00A5) begin errors++; $display("FAIL mmio_a5_out: got %h expected 000000a5", PortOut); end
    wait_retire(n);
    @(negedge clk);
    checks++; if (PortOut !== 32'h0000_003C) begin errors++; $display("FAIL mmio_portin: got %h expected 0000003c", PortOut); end
  endtask

  task automatic test_lw_wait();
    int n;
    int dreq;
    load_begin();
    data_wait = 3;
    imem[0] = f_i(6'h0F, 5'd0, 5'd16, 16'h1001);
    imem[1] = f_i(6'h23, 5'd16, 5'd17, 16'd8);
    imem[2] = f_i(6'h0F, 5'd0, 5'd20, 16'hFFFF);
    imem[3] = f_i(6'h2B, 5'd20, 5'd17, 16'd4);
    imem[4] = f_i(6'h2B, 5'd16, 5'd17, 16'd12);
    reset = 1'b1;
    wait_retire(n);
    dreq = 0;
    n = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (mem_req && is_data) dreq++;
      if (retire) begin
        n = k;
        break;
      end
    end
    checks++; if (n !== 8) begin errors++; $display("FAIL lw_wait_cyc: got %0d expected 8", n); end
    checks++; if (dreq !== 4) begin errors++; $display("FAIL lw_wait_req: got %0d expected 4", dreq); end
    wait_retire(n);
    wait_retire(n);
    wait_retire(n);
    checks++; if (n !== 7) begin errors++; $display("FAIL sw_wait_cyc: got %0d expected 7", n); end
    checks++; if (PortOut !== 32'hBEEF_0008) begin errors++; $display("FAIL lw_wait_data: got %h expected beef0008", PortOut); end
    @(negedge clk);
    checks++; if (wr_count !== 1) begin errors++; $display("FAIL sw_bus_count: got %0d expected 1", wr_count); end
    checks++; if (wr_addr !== 32'h1001_000C) begin errors++; $display("FAIL sw_bus_addr: got %h expected 1001000c", wr_addr); end
    checks++; if (wr_data !== 32'hBEEF_0008) begin errors++; $display("FAIL sw_bus_data: got %h expected beef0008", wr_data); end
  endtask

  task automatic test_reset_mid();
    int n;
    load_begin();
    data_wait = 3;
    imem[0] = f_i(6'h0F, 5'd0, 5'd16, 16'h1001);
    imem[1] = f_i(6'h23, 5'd16, 5'd17, 16'd8);
    reset = 1'b1;
    wait_retire(n);
    repeat (4) @(negedge clk);
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL mid_req_before: got %b expected 1", mem_req); end
    reset = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL mid_req_low: got %b expected 0", mem_req); end
    checks++; if (retire !== 1'b0) begin errors++; $display("FAIL mid_retire: got %b expected 0", retire); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (mem_addr !== RESET_PC) begin errors++; $display("FAIL mid_restart_addr: got %h expected %h", mem_addr, RESET_PC); end
  endtask

  task automatic test_jump();
    int n;
    load_begin();
    imem[0]  = f_i(6'h0F, 5'd0, 5'd20, 16'hFFFF);
    imem[4]  = {6'h03, 26'h010_0010};
    imem[5]  = f_i(6'h08, 5'd0, 5'd21, 16'h0077);
    imem[6]  = f_i(6'h2B, 5'd20, 5'd21, 16'd4);
    imem[16] = f_i(6'h2B, 5'd20, 5'd31, 16'd4);
    imem[17] = f_r(5'd31, 5'd0, 5'd0, 5'd0, 6'h08);
    reset = 1'b1;
    repeat (4) wait_retire(n);
    wait_retire(n);
    checks++; if (n !== 3) begin errors++; $display("FAIL jal_cyc: got %0d expected 3", n); end
    @(negedge clk);
    checks++; if (mem_addr !== 32'h0040_0040) begin errors++; $display("FAIL jal_target: got %h expected 00400040", mem_addr); end
    wait_retire(n);
    wait_retire(n);
    checks++; if (n !== 3) begin errors++; $display("FAIL jr_cyc: got %0d expected 3", n); end
    checks++; if (PortOut !== 32'h0040_0014) begin errors++; $display("FAIL jal_link: got %h expected 00400014", PortOut); end
    @(negedge clk);
    checks++; if (mem_addr !== 32'h0040_0014) begin errors++; $display("FAIL jr_target: got %h expected 00400014", mem_addr); end
    wait_retire(n);
    wait_retire(n);
    @(negedge clk);
    checks++; if (PortOut !== 32'h0000_0077) begin errors++; $display("FAIL jr_resume: got %h expected 00000077", PortOut); end
  endtask

  task automatic test_branch();
    int n;
    load_begin();
    imem[0] = f_i(6'h08, 5'd0, 5'd8, 16'd3);
    imem[1] = f_i(6'h05, 5'd8, 5'd8, 16'd5);
    imem[2] = f_i(6'h04, 5'd8, 5'd8, 16'hFFFE);
    reset = 1'b1;
    wait_retire(n);
    wait_retire(n);
    checks++; if (n !== 3) begin errors++; $display("FAIL bne_cyc: got %0d expected 3", n); end
    @(negedge clk);
    checks++; if (mem_addr !== 32'h0040_0008) begin errors++; $display("FAIL bne_fallthrough: got %h expected 00400008", mem_addr); end
    wait_retire(n);
    checks++; if (n !== 2) begin errors++; $display("FAIL beq_cyc: got %0d expected 2", n); end
    @(negedge clk);
    checks++; if (mem_addr !== 32'h0040_0004) begin errors++; $display("FAIL beq_target: got %h expected 00400004", mem_addr); end
  endtask

  task automatic test_trap();
    int n;
    int rets;
    int reqs;
    load_begin();
    imem[0] = f_i(6'h08, 5'd0, 5'd8, 16'd1);
    imem[1] = 32'hFC00_0000;
    reset = 1'b1;
    wait_retire(n);
    rets = 0;
    reqs = 0;
    repeat (12) begin
      @(negedge clk);
      if (retire) rets++;
      if (mem_req) reqs++;
    end
    checks++; if (rets !== 0) begin errors++; $display("FAIL trap_retire: got %0d expected 0", rets); end
    checks++; if (reqs !== 1) begin errors++; $display("FAIL trap_req: got %0d expected 1", reqs); end
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL trap_halted: got %b expected 1", halted); end
    checks++; if (mem_addr !== 32'h0040_0008) begin errors++; $display("FAIL trap_pc: got %h expected 00400008", mem_addr); end
    checks++; if (ALUResultOut !== 32'h1) begin errors++; $display("FAIL trap_alu: got %h expected 1", ALUResultOut); end
    repeat (5) @(negedge clk);
    checks++; if (mem_addr !== 32'h0040_0008) begin errors++; $display("FAIL trap_pc_frozen: got %h expected 00400008", mem_addr); end
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL trap_exit_halted: got %b expected 0", halted); end
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL trap_exit_req: got %b expected 1", mem_req); end
    checks++; if (mem_addr !== RESET_PC) begin errors++; $display("FAIL trap_exit_addr: got %h expected %h", mem_addr, RESET_PC); end
  endtask

  task automatic test_misaligned();
    int rets;
    int reqs;
    load_begin();
    imem[0] = f_i(6'h23, 5'd0, 5'd8, 16'd2);
    reset = 1'b1;
    rets = 0;
    reqs = 0;
    repeat (10) begin
      @(negedge clk);
      if (retire) rets++;
      if (mem_req) reqs++;
    end
    checks++; if (rets !== 0) begin errors++; $display("FAIL misalign_retire: got %0d expected 0", rets); end
    checks++; if (reqs !== 0) begin errors++; $display("FAIL misalign_req: got %0d expected 0", reqs); end
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL misalign_halted: got %b expected 1", halted); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_mmio();
    test_lw_wait();
    test_reset_mid();
    test_jump();
    test_branch();
    test_trap();
    test_misaligned();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end
endmodule
